// File: rtl/sqrt_stream_sched_if.sv
// Bundle of requester, kernel and result signals around the sqrt-kernel scheduler.
// Latency: none, wiring only.
// Backpressure: none; requests are level-held and the grant/busy pair tells requesters when they own the kernel.
interface sqrt_stream_sched_if #(
    parameter int NREQ      = 4,
    parameter int BITW      = 8,
    parameter int DEPLOG_SR = 2
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      in_bits;
    logic [NREQ-1:0]      grant;
    logic                 busy;
    logic                 kern_clr;
    logic                 kern_in;
    logic                 kern_out;
    logic [DEPLOG_SR-1:0] rand_sel;
    logic                 done;
    logic [IDW-1:0]       done_id;
    logic [BITW:0]        result;

    // Scheduler side
    modport master (
        input  req, in_bits, kern_out,
        output grant, busy, kern_clr, kern_in, rand_sel, done, done_id, result
    );

    // Requesters and kernel side
    modport slave (
        output req, in_bits, kern_out,
        input  grant, busy, kern_clr, kern_in, rand_sel, done, done_id, result
    );
endinterface

// File: rtl/sqrt_stream_sched.sv
// Round-robin time-multiplexer of one unary sqrt kernel: clear, warm up, count ones over 2^BITW cycles.
// Latency: req seen in IDLE at cycle t -> CLEAR at t+1 -> done pulse at t+2+WARM+2^BITW.
// Backpressure: none; jobs run to completion once granted, other requesters wait on level req.
module sqrt_stream_sched #(
    parameter int NREQ      = 4,
    parameter int BITW      = 8,
    parameter int WARM      = 16,
    parameter int DEPLOG_SR = 2
) (
    input  logic                clk,
    input  logic                rst,
    sqrt_stream_sched_if.master io
);
    localparam int IDW = $clog2(NREQ);
    localparam int KW  = IDW + 1;
    localparam int CW  = BITW + 1;
    localparam int WW  = $clog2(WARM + 1);
    localparam int TW  = (WW > BITW) ? WW : BITW;
    localparam logic [TW-1:0] RUN_LAST  = TW'((2 ** BITW) - 1);
    localparam logic [TW-1:0] WARM_LAST = TW'((WARM > 0) ? WARM - 1 : 0);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_WARM, S_RUN, S_DONE} state_t;

    state_t          state;
    logic [IDW-1:0]  rr;
    logic [IDW-1:0]  id;
    logic [IDW-1:0]  pick;
    logic [TW-1:0]   tmr;
    logic [CW-1:0]   cnt;
    logic [7:0]      lfsr;
    logic            feed;
    logic [NREQ-1:0] grant_q;
    logic            busy_q;
    logic            clr_q;
    logic            done_q;
    logic [IDW-1:0]  done_id_q;
    logic [CW-1:0]   result_q;

    // First set request at or above the rr pointer, wrapping; lowest offset wins.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [IDW-1:0] p);
        logic [IDW-1:0] sel;
        logic [KW-1:0]  k;
        sel = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            k = {1'b0, p} + KW'(i);
            if (k >= KW'(NREQ)) k = k - KW'(NREQ);
            if (r[k[IDW-1:0]]) sel = k[IDW-1:0];
        end
        return sel;
    endfunction

    assign pick = rr_pick(io.req, rr);

    // Free-running random select source; seed 8'h01 keeps it out of the all-zero lock-up state.
    always_ff @(posedge clk) begin
        if (rst) lfsr <= 8'h01;
        else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    // Job sequencer: owner selection, phase timing, ones counting and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rr        <= '0;
            id        <= '0;
            tmr       <= '0;
            cnt       <= '0;
            feed      <= 1'b0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            clr_q     <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            result_q  <= '0;
        end else begin
            clr_q  <= 1'b0;
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (|io.req) begin
                        id      <= pick;
                        grant_q <= NREQ'(1) << pick;
                        busy_q  <= 1'b1;
                        clr_q   <= 1'b1;
                        state   <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    cnt  <= '0;
                    feed <= 1'b1;
                    if (WARM == 0) begin
                        state <= S_RUN;
                        tmr   <= RUN_LAST;
                    end else begin
                        state <= S_WARM;
                        tmr   <= WARM_LAST;
                    end
                end
                S_WARM: begin
                    if (tmr == '0) begin
                        state <= S_RUN;
                        tmr   <= RUN_LAST;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                S_RUN: begin
                    cnt <= cnt + CW'(io.kern_out);
                    if (tmr == '0) begin
                        // Last RUN cycle still contributes its kern_out bit.
                        result_q  <= cnt + CW'(io.kern_out);
                        done_id_q <= id;
                        done_q    <= 1'b1;
                        feed      <= 1'b0;
                        state     <= S_DONE;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                S_DONE: begin
                    rr      <= (id == IDW'(NREQ - 1)) ? '0 : id + 1'b1;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign io.grant    = grant_q;
    assign io.busy     = busy_q;
    assign io.kern_clr = clr_q;
    assign io.kern_in  = feed & io.in_bits[id];
    assign io.rand_sel = lfsr[DEPLOG_SR-1:0];
    assign io.done     = done_q;
    assign io.done_id  = done_id_q;
    assign io.result   = result_q;
endmodule

// File: tb/tb_sqrt_stream_sched.sv
module tb_sqrt_stream_sched;
    localparam int NREQ     = 4;
    localparam int BITW     = 8;
    localparam int WARM     = 16;
    localparam int RUNLEN   = 1 << BITW;
    localparam int LAST_RUN = WARM + RUNLEN;
    localparam int DONE_OFF = WARM + RUNLEN + 1;

    logic clk = 1'b0;
    logic rst;
    logic [3:0] req_v, in_v, req2;
    logic kout_v;

    always #5 clk = ~clk;

    sqrt_stream_sched_if #(.NREQ(4), .BITW(8), .DEPLOG_SR(2)) ifc ();
    sqrt_stream_sched_if #(.NREQ(4), .BITW(3), .DEPLOG_SR(2)) ifc2 ();

    assign ifc.req       = req_v;
    assign ifc.in_bits   = in_v;
    assign ifc.kern_out  = kout_v;
    assign ifc2.req      = req2;
    assign ifc2.in_bits  = in_v;
    assign ifc2.kern_out = 1'b1;

    sqrt_stream_sched #(.NREQ(4), .BITW(8), .WARM(16), .DEPLOG_SR(2)) dut (
        .clk(clk), .rst(rst), .io(ifc.master)
    );
    sqrt_stream_sched #(.NREQ(4), .BITW(3), .WARM(0), .DEPLOG_SR(2)) dut_w0 (
        .clk(clk), .rst(rst), .io(ifc2.master)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mode = 0;          // kern_out pattern: 0 random, 1 all ones, 2 toggle in RUN, 3 ones only in WARM

    // Job-level reference model
    bit         m_job = 1'b0;
    int         m_id, m_clear, m_rr, m_cnt, m_result, m_done_id;
    logic [7:0] m_lfsr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & 8'hB8)};
    endfunction

    function automatic bit bit_of(input logic [3:0] v, input int i);
        return ((v >> i) & 4'b0001) != 4'b0000;
    endfunction

    function automatic int pick_rr(input logic [3:0] r, input int p);
        for (int i = 0; i < NREQ; i++)
            if (bit_of(r, (p + i) % NREQ)) return (p + i) % NREQ;
        return -1;
    endfunction

    // Phase offset of the current cycle within the active job (0 = CLEAR).
    function automatic int off();
        return cyc - m_clear;
    endfunction

    task automatic gen_stim();
        int o;
        o = off();
        in_v = 4'($urandom);
        case (mode)
            1: kout_v = 1'b1;
            2: kout_v = (m_job && o > WARM && o <= LAST_RUN) ? ((o - WARM - 1) % 2 == 0) : 1'($urandom);
            3: kout_v = (m_job && o >= 1 && o <= WARM);
            default: kout_v = 1'($urandom);
        endcase
    endtask

    // Apply what the scheduler does at the edge ending the current cycle.
    task automatic model_edge();
        int o;
        if (rst) begin
            m_job = 1'b0; m_rr = 0; m_result = 0; m_done_id = 0; m_lfsr = 8'h01;
            return;
        end
        m_lfsr = lfsr_next(m_lfsr);
        if (!m_job) begin
            if (req_v != 4'b0) begin
                m_id = pick_rr(req_v, m_rr); m_job = 1'b1; m_clear = cyc + 1; m_cnt = 0;
            end
        end else begin
            o = off();
            if (o > WARM && o <= LAST_RUN) m_cnt += int'(kout_v);
            if (o == LAST_RUN) begin m_result = m_cnt; m_done_id = m_id; end
            if (o == DONE_OFF) begin m_job = 1'b0; m_rr = (m_id + 1) % NREQ; end
        end
    endtask

    task automatic check_outputs();
        int o;
        bit in_phase;
        o = off();
        in_phase = m_job && o >= 1 && o <= LAST_RUN;
        chk("grant",    32'(ifc.grant),    m_job ? (32'd1 << m_id) : 32'd0);
        chk("busy",     32'(ifc.busy),     32'(m_job));
        chk("kern_clr", 32'(ifc.kern_clr), 32'(m_job && o == 0));
        chk("done",     32'(ifc.done),     32'(m_job && o == DONE_OFF));
        chk("done_id",  32'(ifc.done_id),  32'(m_done_id));
        chk("result",   32'(ifc.result),   32'(m_result));
        chk("kern_in",  32'(ifc.kern_in),  in_phase ? 32'(bit_of(in_v, m_id)) : 32'd0);
        chk("rand_sel", 32'(ifc.rand_sel), 32'(m_lfsr[1:0]));
    endtask

    task automatic tick();
        gen_stim();
        model_edge();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic wait_done(output int id, output int res, output int at);
        bit seen;
        seen = 1'b0; id = -1; res = -1; at = -1;
        for (int i = 0; i < 1000 && !seen; i++) begin
            tick();
            if (ifc.done === 1'b1) begin
                seen = 1'b1; id = int'(ifc.done_id); res = int'(ifc.result); at = cyc;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int id, res, at, t, o;
        logic [1:0] exp_rs [0:7];
        exp_rs = '{2'd1, 2'd2, 2'd0, 2'd0, 2'd1, 2'd3, 2'd3, 2'd2};

        rst = 1'b1; req_v = 4'b0; req2 = 4'b0; in_v = 4'b0; kout_v = 1'b0;
        @(negedge clk);
        repeat (3) tick();
        chk("rst_grant", 32'(ifc.grant), 32'd0);
        chk("rst_result", 32'(ifc.result), 32'd0);
        chk("rst_lfsr", 32'(ifc.rand_sel), 32'd1);
        rst = 1'b0;
        repeat (3) tick();

        // Single request, kernel output all ones
        mode = 1; req_v = 4'b0100; t = cyc;
        tick();
        chk("t1_grant", 32'(ifc.grant), 32'h4);
        chk("t1_clr", 32'(ifc.kern_clr), 32'd1);
        req_v = 4'b0;
        tick();
        chk("t1_clr_once", 32'(ifc.kern_clr), 32'd0);
        wait_done(id, res, at);
        chk("t1_latency", 32'(at - t), 32'd274);
        chk("t1_id", 32'(id), 32'd2);
        chk("t1_result", 32'(res), 32'd256);
        tick();

        // Toggling kernel output from the first RUN cycle
        mode = 2; req_v = 4'b1000;
        tick();
        req_v = 4'b0;
        wait_done(id, res, at);
        chk("t2_id", 32'(id), 32'd3);
        chk("t2_result", 32'(res), 32'd128);
        tick();

        // All requesters held high: four back-to-back jobs
        mode = 0; req_v = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_done(id, res, at);
            chk("t4_id", 32'(id), 32'(k));
            if (k == 3) req_v = 4'b0;
            tick();
            chk("t4_gap", 32'(ifc.grant), 32'd0);
            if (k < 3) begin
                tick();
                chk("t4_next", 32'(ifc.grant), 32'd1 << (k + 1));
            end
        end

        // Kernel output high only during warm-up must not count
        mode = 3; req_v = 4'b0001;
        tick();
        req_v = 4'b0;
        wait_done(id, res, at);
        chk("t3_id", 32'(id), 32'd0);
        chk("t3_result", 32'(res), 32'd0);
        tick();

        // req[1] dropped mid-RUN: job completes, next grant goes to req[3]
        mode = 0; req_v = 4'b1010;
        tick();
        chk("t5_grant", 32'(ifc.grant), 32'h2);
        repeat (WARM + RUNLEN / 2) tick();
        req_v = 4'b1000;
        wait_done(id, res, at);
        chk("t5_id", 32'(id), 32'd1);
        tick();
        tick();
        chk("t5_next", 32'(ifc.grant), 32'h8);
        req_v = 4'b0;
        wait_done(id, res, at);
        chk("t5_id2", 32'(id), 32'd3);
        tick();

        // Reset pulsed during RUN
        req_v = 4'b0001;
        tick();
        req_v = 4'b0;
        repeat (WARM + 50) tick();
        rst = 1'b1;
        tick();
        chk("t6_grant", 32'(ifc.grant), 32'd0);
        chk("t6_busy", 32'(ifc.busy), 32'd0);
        chk("t6_result", 32'(ifc.result), 32'd0);
        rst = 1'b0; req_v = 4'b1000;
        chk("t6_lfsr0", 32'(ifc.rand_sel), 32'(exp_rs[0]));
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("t6_lfsr", 32'(ifc.rand_sel), 32'(exp_rs[i]));
            if (i == 1) begin
                chk("t6_regrant", 32'(ifc.grant), 32'h8);
                req_v = 4'b0;
            end
        end
        wait_done(id, res, at);
        chk("t6_id", 32'(id), 32'd3);
        tick();

        // WARM=0 build: CLEAR straight into an 8-cycle RUN
        req2 = 4'b0010;
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (k == 1) req2 = 4'b0;
            o = k - 1;
            chk("w0_grant", 32'(ifc2.grant), (o <= 9) ? 32'h2 : 32'd0);
            chk("w0_clr", 32'(ifc2.kern_clr), 32'(o == 0));
            chk("w0_kern_in", 32'(ifc2.kern_in), (o >= 1 && o <= 8) ? 32'(bit_of(in_v, 1)) : 32'd0);
            chk("w0_done", 32'(ifc2.done), 32'(o == 9));
            if (o == 9) begin
                chk("w0_result", 32'(ifc2.result), 32'd8);
                chk("w0_id", 32'(ifc2.done_id), 32'd1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sqrt_stream_sched.md
Name: sqrt_stream_sched

Overview:
- Time-multiplexes one bipolar unary square-root kernel among NREQ requesters.
- Each requester supplies a bipolar input bitstream. The scheduler grants the kernel to one requester at a time, round-robin.
- For each job it clears the kernel, discards WARM warm-up output cycles, then counts kernel output ones over 2^BITW cycles.
- The count is returned as a binary result with a one-cycle done pulse.
- It sits between the requester stream generators and the sqrt kernel. It also supplies the kernel's shift-register random select.

Parameters:
- NREQ, 4, number of requesters (2..16).
- BITW, 8, log2 of measured stream length; RUN lasts 2^BITW cycles.
- WARM, 16, warm-up cycles whose kernel output is discarded (0 allowed).
- DEPLOG_SR, 2, width of the kernel random select (1..8).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req  in  NREQ  per-requester job request, level.
- in_bits  in  NREQ  per-requester bipolar input stream bit.
- grant  out  NREQ  one-hot owner of kernel, all-zero when idle.
- busy  out  1  high in any state except IDLE.
- kern_clr  out  1  one-cycle clear pulse to kernel state.
- kern_in  out  1  muxed stream bit to kernel.
- kern_out  in  1  kernel output bit.
- rand_sel  out  DEPLOG_SR  random shift-register select to kernel.
- done  out  1  one-cycle result-valid pulse.
- done_id  out  clog2(NREQ)  requester index of finished job.
- result  out  BITW+1  count of ones in RUN window (0..2^BITW).

Behaviour:
- One clock. Reset is synchronous and active-high. The clock port is clk and the reset port is rst.
- Values while rst is high and in the first cycle after it:
  - state=IDLE, rr pointer=0.
  - grant=0, busy=0, kern_clr=0, done=0, done_id=0, result=0.
  - LFSR=8'h01.
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1.
  - Advances every cycle regardless of state.
  - rand_sel = LFSR[DEPLOG_SR-1:0].
  - Never reaches all-zero.
- FSM states: IDLE, CLEAR, WARM, RUN, DONE.
- IDLE:
  - If req is nonzero, pick the first set bit searching from rr pointer upward with wrap; latch it as owner id; go to CLEAR.
  - If req is zero, stay in IDLE.
- CLEAR:
  - Lasts 1 cycle. grant=onehot(id) and kern_clr=1.
  - Next state is WARM, or RUN if WARM==0.
- WARM:
  - Lasts WARM cycles. kern_out is ignored.
- RUN:
  - Lasts exactly 2^BITW cycles.
  - The counter starts at 0 and adds kern_out each RUN cycle, including the last.
- DONE:
  - Lasts 1 cycle. done=1, done_id=id, result=final count.
  - result holds its value until the next DONE.
  - grant is still asserted in DONE.
  - rr pointer becomes id+1 mod NREQ. Next state is IDLE.
- kern_in = in_bits[id] in WARM and RUN, 0 in IDLE, CLEAR and DONE.
- grant is asserted in CLEAR through DONE and is zero in IDLE.
- Latency: with req sampled in IDLE at cycle t, CLEAR is at t+1 and done is at t+2+WARM+2^BITW.
- A job always runs to completion once granted; deasserting req mid-job has no effect.
- After DONE, at least one IDLE cycle precedes the next grant.
- The same requester may be re-granted only if no other req bit is set.
- Counter width is BITW+1, so the all-ones case 2^BITW is not lost to wrap.
- rst asserted in any state:
  - Returns to IDLE in the next cycle with grant=0.
  - No done is issued; result is cleared to 0.
  - rr pointer returns to 0.

Test Plan:
- Single request, kern_out tied 1, BITW=8, WARM=16: req[2] at cycle t.
  - Expected: grant=4'b0100 from t+1; kern_clr only at t+1; done at t+274 with done_id=2, result=256.
- kern_out toggling 1,0 starting in the first RUN cycle, BITW=8.
  - Expected: result=128.
  - A variant that drives kern_out=1 only during WARM must give result=0.
- All four req held high for four jobs.
  - Expected: done_id sequence 0,1,2,3; grant is zero for exactly one cycle between jobs.
- req[1] dropped in the middle of RUN.
  - Expected: the job still completes with done_id=1; the next grant goes to the next set req bit.
- rst pulsed during RUN.
  - Expected: next cycle state=IDLE, grant=0, result=0; no done.
  - After reset, req[3] alone is granted and a fresh LFSR sequence from 8'h01 is seen on rand_sel.
- WARM=0 build.
  - Expected: CLEAR goes directly to RUN; done at t+2+2^BITW; kern_in follows the owner's in_bits in RUN only.
